// File: rtl/cache_fill_ctrl_pkg.sv
// Shared definitions for the cache line fill controller.
//   - fill_state_e : FSM encoding (IDLE, FILL)
//   - clog2_min1   : index width helper that never returns 0, so 1-entry
//                    ranges still get a 1-bit field
//   - WORD_IDX_W, ID_W, OUT_W : widths for the default configuration
//                    (8 words/line, 2 requesters, 4 outstanding reads)
package cache_fill_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  localparam int WORD_IDX_W = clog2_min1(8);
  localparam int ID_W       = clog2_min1(2);
  localparam int OUT_W      = clog2_min1(4 + 1);

endpackage

// File: rtl/cache_fill_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after the
// pointer, wrapping past N_REQ-1 back to 0.
//   req_i   : request vector
//   ptr_i   : highest-priority index this cycle
//   grant_o : chosen index (0 when nothing is requested)
//   any_o   : at least one request is asserted
module rr_arbiter
  import cache_fill_ctrl_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int GID_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [GID_W-1:0] ptr_i,
  output logic [GID_W-1:0] grant_o,
  output logic             any_o
);

  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!any_o && req_i[(int'(ptr_i) + k) % N_REQ]) begin
        any_o   = 1'b1;
        grant_o = GID_W'((int'(ptr_i) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Multi-requester cache line fill controller.
// Arbitrates round-robin among N_REQ miss sources, then fetches the whole
// block-aligned line from an in-order pipelined memory with up to MAX_OUT
// reads in flight, driving data/tag array write strobes as words return.
//   clk, rst           : clock, asynchronous active-high reset
//   miss_detected      : per-requester miss, held until its fill_done
//   miss_address       : per-requester byte address, packed ADDR_W each
//   mem_req_valid/ready, memory_address : read request handshake
//   memory_data, memory_data_valid      : in-order read returns
//   fsm_busy, grant_id : grant cycle through last write; served requester
//   write_data_array, word_num          : data array write strobe + index
//   write_tag_array, fill_done          : final write, one-hot done pulse
module cache_fill_ctrl
  import cache_fill_ctrl_pkg::*;
#(
  parameter  int ADDR_W  = 16,
  parameter  int DATA_W  = 16,
  parameter  int WORD_B  = 2,
  parameter  int WORDS   = 8,
  parameter  int N_REQ   = 2,
  parameter  int MAX_OUT = 4,
  localparam int IDX_W   = clog2_min1(WORDS),
  localparam int GID_W   = clog2_min1(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        miss_detected,
  input  logic [N_REQ*ADDR_W-1:0] miss_address,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_W-1:0]       memory_address,
  input  logic [DATA_W-1:0]       memory_data,
  input  logic                    memory_data_valid,
  output logic                    fsm_busy,
  output logic [GID_W-1:0]        grant_id,
  output logic                    write_data_array,
  output logic                    write_tag_array,
  output logic [IDX_W-1:0]        word_num,
  output logic [N_REQ-1:0]        fill_done
);

  localparam int ICNT_W = $clog2(WORDS + 1);
  localparam int OCNT_W = $clog2(MAX_OUT + 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(WORDS * WORD_B - 1);

  fill_state_e       state_q, state_d;
  logic [GID_W-1:0]  rr_q, rr_d;
  logic [GID_W-1:0]  grant_q, grant_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ICNT_W-1:0] issue_q, issue_d;
  logic [IDX_W-1:0]  ret_q, ret_d;
  logic [OCNT_W-1:0] outst_q, outst_d;

  logic [GID_W-1:0]  arb_gnt;
  logic              arb_any;
  logic [ADDR_W-1:0] arb_addr;
  logic              hs;
  logic              ret;

  // Returned words go straight from memory to the data array in the parent;
  // the port is carried here only so the interface is complete.
  logic unused_data;
  assign unused_data = ^memory_data;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .GID_W (GID_W)
  ) u_arb (
    .req_i   (miss_detected),
    .ptr_i   (rr_q),
    .grant_o (arb_gnt),
    .any_o   (arb_any)
  );

  always_comb begin
    arb_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (int'(arb_gnt) == i) arb_addr = miss_address[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    state_d          = state_q;
    rr_d             = rr_q;
    grant_d          = grant_q;
    base_d           = base_q;
    issue_d          = issue_q;
    ret_d            = ret_q;
    outst_d          = outst_q;
    fsm_busy         = 1'b0;
    grant_id         = grant_q;
    mem_req_valid    = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    word_num         = '0;
    fill_done        = '0;
    hs               = 1'b0;
    ret              = 1'b0;

    case (state_q)
      IDLE: begin
        // Grant is visible in the same cycle the miss is seen.
        if (arb_any) begin
          fsm_busy = 1'b1;
          grant_id = arb_gnt;
          grant_d  = arb_gnt;
          base_d   = arb_addr & ~LINE_MASK;
          rr_d     = (int'(arb_gnt) == N_REQ - 1) ? '0 : arb_gnt + GID_W'(1);
          state_d  = FILL;
        end
      end
      FILL: begin
        fsm_busy      = 1'b1;
        mem_req_valid = (issue_q < ICNT_W'(WORDS)) && (outst_q < OCNT_W'(MAX_OUT));
        if (mem_req_valid) begin
          // Base is line-aligned, so the offset never carries out of the line.
          memory_address = base_q + ADDR_W'(issue_q) * ADDR_W'(WORD_B);
        end
        hs  = mem_req_valid && mem_req_ready;
        ret = memory_data_valid;
        if (hs) issue_d = issue_q + ICNT_W'(1);
        if (ret) begin
          write_data_array = 1'b1;
          word_num         = ret_q;
          ret_d            = ret_q + IDX_W'(1);
        end
        case ({hs, ret})
          2'b10:   outst_d = outst_q + OCNT_W'(1);
          2'b01:   outst_d = outst_q - OCNT_W'(1);
          default: outst_d = outst_q;
        endcase
        if (ret && (ret_q == IDX_W'(WORDS - 1))) begin
          write_tag_array = 1'b1;
          for (int i = 0; i < N_REQ; i++) fill_done[i] = (int'(grant_q) == i);
          state_d = IDLE;
          issue_d = '0;
          ret_d   = '0;
          outst_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      grant_q <= '0;
      issue_q <= '0;
      ret_q   <= '0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      issue_q <= issue_d;
      ret_q   <= ret_d;
      outst_q <= outst_d;
    end
  end

  // Line base is only consumed while FILL is active, so it carries no reset.
  always_ff @(posedge clk) begin
    base_q <= base_d;
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
module tb_cache_fill_ctrl;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 16;
  localparam int WORD_B  = 2;
  localparam int WORDS   = 8;
  localparam int N_REQ   = 2;
  localparam int MAX_OUT = 4;

  logic                    clk;
  logic                    rst;
  logic [N_REQ-1:0]        miss_detected;
  logic [N_REQ*ADDR_W-1:0] miss_address;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [ADDR_W-1:0]       memory_address;
  logic [DATA_W-1:0]       memory_data;
  logic                    memory_data_valid;
  logic                    fsm_busy;
  logic [0:0]              grant_id;
  logic                    write_data_array;
  logic                    write_tag_array;
  logic [2:0]              word_num;
  logic [N_REQ-1:0]        fill_done;

  cache_fill_ctrl #(
    .ADDR_W (ADDR_W), .DATA_W (DATA_W), .WORD_B (WORD_B),
    .WORDS (WORDS), .N_REQ (N_REQ), .MAX_OUT (MAX_OUT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .memory_address    (memory_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .grant_id          (grant_id),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .word_num          (word_num),
    .fill_done         (fill_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_addr_q[$];
  int          exp_word_q[$];
  int          exp_gid_q[$];
  int          exp_done_q[$];
  int          due_q[$];

  int          lat         = 1;
  int          stall_left  = 0;
  bit          force_stray = 0;
  bit          lat_chk     = 0;
  int          cyc         = 0;
  int          outst_tb    = 0;
  int          peak        = 0;
  int          wr_cnt      = 0;
  int          grant_cyc   = 0;
  bit          first_pend  = 0;
  bit          busy_prev   = 0;
  bit          tag_prev    = 0;
  bit          vld_prev    = 0;
  bit          rdy_prev    = 0;
  logic [15:0] addr_prev   = '0;
  logic [N_REQ-1:0] clr_mask = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_fill(input int id, input logic [15:0] a);
    logic [15:0] base;
    base = a & ~16'(WORDS * WORD_B - 1);
    for (int w = 0; w < WORDS; w++) begin
      exp_addr_q.push_back(base + 16'(w * WORD_B));
      exp_word_q.push_back(w);
      exp_gid_q.push_back(id);
    end
    exp_done_q.push_back(1 << id);
  endtask

  task automatic set_miss(input int id, input logic [15:0] a);
    miss_address[id*ADDR_W +: ADDR_W] = a;
    miss_detected[id] = 1'b1;
  endtask

  task automatic wait_fills(input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      #2;
      if (exp_word_q.size() == 0 && !fsm_busy) break;
      n++;
    end
    chk("fill_timeout", n < budget, 1);
    chk("addr_q_empty", exp_addr_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    miss_detected = '0;
    exp_addr_q.delete();
    exp_word_q.delete();
    exp_gid_q.delete();
    exp_done_q.delete();
    outst_tb = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Memory model and output monitor: inputs change at the falling edge,
  // outputs are sampled 1 time unit later.
  initial begin
    mem_req_ready     = 1'b0;
    memory_data_valid = 1'b0;
    memory_data       = '0;
    forever begin
      @(negedge clk);
      cyc++;
      miss_detected = miss_detected & ~clr_mask;
      clr_mask      = '0;
      mem_req_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      memory_data_valid = 1'b0;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        void'(due_q.pop_front());
        memory_data_valid = 1'b1;
      end
      if (force_stray) memory_data_valid = 1'b1;
      memory_data = DATA_W'($urandom);
      #1;
      if (rst) begin
        busy_prev = 0; tag_prev = 0; vld_prev = 0; rdy_prev = 0; first_pend = 0;
      end else begin
        if (fsm_busy && (!busy_prev || tag_prev)) begin
          grant_cyc  = cyc;
          first_pend = 1;
        end
        if (tag_prev && miss_detected != '0) chk("no_gap_busy", fsm_busy, 1);
        if (mem_req_valid) begin
          if (vld_prev && !rdy_prev) chk("addr_hold", memory_address, addr_prev);
          if (first_pend) begin
            if (lat_chk) chk("first_req_lat", cyc - grant_cyc, 1);
            first_pend = 0;
          end
          if (mem_req_ready) begin
            if (exp_addr_q.size() == 0) chk("unexp_req", memory_address, 32'hDEAD);
            else chk("req_addr", memory_address, exp_addr_q.pop_front());
            due_q.push_back(cyc + lat);
            outst_tb++;
            if (outst_tb > peak) peak = outst_tb;
            chk("outst_le_max", outst_tb <= MAX_OUT, 1);
          end
        end
        if (write_data_array) begin
          outst_tb--;
          wr_cnt++;
          if (exp_word_q.size() == 0) chk("unexp_wr", write_data_array, 0);
          else begin
            chk("word_num", word_num, exp_word_q.pop_front());
            chk("grant_id", grant_id, exp_gid_q.pop_front());
          end
        end
        if (write_tag_array) begin
          chk("tag_with_data", write_data_array, 1);
          if (exp_done_q.size() == 0) chk("unexp_done", fill_done, 0);
          else chk("fill_done", fill_done, exp_done_q.pop_front());
          if (lat_chk) chk("last_wr_lat", cyc - grant_cyc, WORDS + 1);
          clr_mask = fill_done;
        end else if (fill_done != '0) begin
          chk("done_without_tag", fill_done, 0);
        end
        busy_prev = fsm_busy;
        tag_prev  = write_tag_array;
        vld_prev  = mem_req_valid;
        rdy_prev  = mem_req_ready;
        addr_prev = memory_address;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int n;
    rst           = 1'b1;
    miss_detected = '0;
    miss_address  = '0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_busy", fsm_busy, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_wr_data", write_data_array, 0);
    chk("rst_wr_tag", write_tag_array, 0);
    chk("rst_fill_done", fill_done, 0);
    chk("rst_grant_id", grant_id, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single miss, 1-cycle memory, latency checked
    lat = 1; lat_chk = 1;
    push_fill(0, 16'h1234);
    set_miss(0, 16'h1234);
    wait_fills(60);
    lat_chk = 0;

    // Both miss right after reset: req0 then req1, twice
    do_reset();
    push_fill(0, 16'h0100); push_fill(1, 16'h0200);
    set_miss(0, 16'h0100); set_miss(1, 16'h0200);
    wait_fills(100);
    push_fill(0, 16'h0310); push_fill(1, 16'h0420);
    set_miss(0, 16'h0310); set_miss(1, 16'h0420);
    wait_fills(100);
    // req0 alone moves the pointer to 1, so req1 wins the next tie
    push_fill(0, 16'h0500);
    set_miss(0, 16'h0500);
    wait_fills(60);
    push_fill(1, 16'h0620); push_fill(0, 16'h0710);
    set_miss(0, 16'h0710); set_miss(1, 16'h0620);
    wait_fills(100);

    // Slow memory: outstanding reads cap at MAX_OUT
    lat = 6; peak = 0;
    push_fill(1, 16'h5550);
    set_miss(1, 16'h5550);
    wait_fills(200);
    chk("outst_peak", peak, MAX_OUT);

    // Ready held low mid-fill
    lat = 1;
    push_fill(0, 16'h7000);
    set_miss(0, 16'h7000);
    repeat (4) @(negedge clk);
    #2 stall_left = 3;
    wait_fills(60);

    // Reset after 3 returns, then stray responses
    lat = 2;
    w0 = wr_cnt;
    push_fill(0, 16'h2468);
    set_miss(0, 16'h2468);
    n = 0;
    while (wr_cnt < w0 + 3 && n < 60) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("mid_fill_reached", wr_cnt >= w0 + 3, 1);
    rst = 1'b1;
    miss_detected = '0;
    exp_addr_q.delete(); exp_word_q.delete(); exp_gid_q.delete(); exp_done_q.delete();
    outst_tb = 0;
    #1;
    chk("midrst_busy", fsm_busy, 0);
    chk("midrst_req_valid", mem_req_valid, 0);
    chk("midrst_wr_data", write_data_array, 0);
    chk("midrst_wr_tag", write_tag_array, 0);
    chk("midrst_fill_done", fill_done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    force_stray = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #2;
      chk("stray_no_wr", write_data_array, 0);
      chk("stray_no_busy", fsm_busy, 0);
    end
    force_stray = 0;
    repeat (6) @(negedge clk);
    push_fill(0, 16'h3000);
    set_miss(0, 16'h3000);
    wait_fills(100);

    // Spurious valid in IDLE, then a fill that sits at the top of memory
    force_stray = 1;
    repeat (2) begin
      @(negedge clk);
      #2;
      chk("idle_stray_no_wr", write_data_array, 0);
    end
    force_stray = 0;
    @(negedge clk);
    lat = 1;
    push_fill(1, 16'hFFFA);
    set_miss(1, 16'hFFFA);
    wait_fills(60);

    chk("done_q_empty", exp_done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
